// File: rtl/if_pkg.sv
// if_pkg: shared default widths and fetch entry type for the instruction-fetch queue
package if_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int PC_INC = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with single-cycle flush
//   in : clk_i, rst_ni (sync, active-low), push_i, data_i, pop_i, flush_i
//   out: head_o (entry at read pointer), count_o (occupied entries)
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= data_i;
  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: PC walker with single-outstanding imem requests and a prefetch queue to decode
//   imem side  : o_i_valid_addr/o_i_addr request, i_i_valid_inst/i_i_inst response
//   control    : i_redirect_valid/i_redirect_addr flush+refetch, i_inst_finish retire (BLOCKING)
//   decode side: o_inst_valid/o_inst/o_inst_addr head, i_inst_ready accept, o_count occupancy
module if_prefetch_queue import if_pkg::*; #(
  parameter int              XLEN     = if_pkg::XLEN,
  parameter int              ILEN     = if_pkg::ILEN,
  parameter int              DEPTH    = 4,
  parameter int              PC_INC   = if_pkg::PC_INC,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              BLOCKING = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_i_valid_addr,
  output logic [XLEN-1:0]            o_i_addr,
  input  logic                       i_i_valid_inst,
  input  logic [ILEN-1:0]            i_i_inst,
  input  logic                       i_redirect_valid,
  input  logic [XLEN-1:0]            i_redirect_addr,
  input  logic                       i_inst_finish,
  output logic                       o_inst_valid,
  output logic [ILEN-1:0]            o_inst,
  output logic [XLEN-1:0]            o_inst_addr,
  input  logic                       i_inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d, drop_q, drop_d, credit_q, credit_d;
  logic            req, resp, push, pop, inst_valid;
  logic [CW-1:0]   count;
  entry_t          head;
  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .data_i  ({req_pc_q, i_i_inst}),
    .pop_i   (pop),
    .flush_i (i_redirect_valid),
    .head_o  (head),
    .count_o (count)
  );
  // Requests only when a slot is guaranteed for the response, so push never overflows.
  // A redirect discards a same-cycle response; an in-flight one is marked to be dropped.
  always_comb begin
    resp          = i_i_valid_inst && outstanding_q;
    req           = i_rst_n && !outstanding_q && count < CW'(DEPTH) && !i_redirect_valid;
    push          = resp && !drop_q && !i_redirect_valid;
    inst_valid    = i_rst_n && count != '0 && (credit_q || BLOCKING == 0) && !i_redirect_valid;
    pop           = inst_valid && i_inst_ready;
    fetch_pc_d    = i_redirect_valid ? i_redirect_addr : req ? fetch_pc_q + XLEN'(PC_INC) : fetch_pc_q;
    req_pc_d      = req ? fetch_pc_q : req_pc_q;
    outstanding_d = req || (outstanding_q && !i_i_valid_inst);
    drop_d        = i_redirect_valid ? outstanding_q && !i_i_valid_inst : drop_q && !resp;
    credit_d      = !pop && (i_redirect_valid || i_inst_finish || credit_q);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      credit_q      <= 1'b1;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      credit_q      <= credit_d;
    end
  end
  assign o_i_valid_addr = req;
  assign o_i_addr       = i_rst_n ? fetch_pc_q : '0;
  assign o_inst_valid   = inst_valid;
  assign o_inst         = inst_valid ? head.inst : '0;
  assign o_inst_addr    = inst_valid ? head.pc : '0;
  assign o_count        = i_rst_n ? count : '0;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: random stimulus on a free-issue and a blocking instance against a queue-based model
module tb_if_prefetch_queue;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n [2], redir [2], vinst [2], fin [2], rdy [2];
  logic [63:0] raddr [2];
  logic [31:0] idat [2];
  logic        req [2], ival [2];
  logic [63:0] addr [2], iaddr [2];
  logic [31:0] inst [2];
  logic [2:0]  cnt_o [2];
  ent_t        mq [2][$];
  logic [63:0] mpc [2], mrpc [2];
  logic [63:0] rpc [2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
  bit          mo [2], mdrop [2], mc [2], pend [2], stale [2];
  int          lat [2];
  logic [31:0] pdat [2];
  int          total = 0, bad = 0;
  if_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h0), .BLOCKING(0)) u_free (
    .i_clk(clk), .i_rst_n(rst_n[0]), .o_i_valid_addr(req[0]), .o_i_addr(addr[0]),
    .i_i_valid_inst(vinst[0]), .i_i_inst(idat[0]), .i_redirect_valid(redir[0]),
    .i_redirect_addr(raddr[0]), .i_inst_finish(fin[0]), .o_inst_valid(ival[0]),
    .o_inst(inst[0]), .o_inst_addr(iaddr[0]), .i_inst_ready(rdy[0]), .o_count(cnt_o[0])
  );
  if_prefetch_queue #(.DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .BLOCKING(1)) u_blk (
    .i_clk(clk), .i_rst_n(rst_n[1]), .o_i_valid_addr(req[1]), .o_i_addr(addr[1]),
    .i_i_valid_inst(vinst[1]), .i_i_inst(idat[1]), .i_redirect_valid(redir[1]),
    .i_redirect_addr(raddr[1]), .i_inst_finish(fin[1]), .o_inst_valid(ival[1]),
    .o_inst(inst[1]), .o_inst_addr(iaddr[1]), .i_inst_ready(rdy[1]), .o_count(cnt_o[1])
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input int d, input int c);
    bit r = c < 3 || (c > 70 && $urandom % 300 == 0);
    rst_n[d] = !r;
    rdy[d]   = c < 40 ? 1'b1 : c < 70 ? 1'b0 : ($urandom % 4 != 0);
    redir[d] = c >= 70 && !r && $urandom % 16 == 0;
    raddr[d] = {$urandom, $urandom} & ~64'h3;
    fin[d]   = $urandom % 3 == 0;
    vinst[d] = 1'b0;
    idat[d]  = $urandom;
    if (r) begin
      if (pend[d]) stale[d] = 1;
      pend[d] = 0;
    end else if (stale[d]) begin
      vinst[d] = 1'b1;
      stale[d] = 0;
    end else if (pend[d]) begin
      if (lat[d] == 0) begin
        vinst[d] = 1'b1;
        idat[d]  = pdat[d];
        pend[d]  = 0;
      end else lat[d]--;
    end else if (c >= 70 && $urandom % 8 == 0) vinst[d] = 1'b1;
  endtask
  task automatic step(input int d, input int c);
    int    n = mq[d].size();
    bit    ereq, eiv;
    ent_t  h;
    string p = $sformatf("c%0d d%0d", c, d);
    if (!rst_n[d]) begin
      chk({p, " rst req"}, 64'(req[d]), 64'h0);
      chk({p, " rst addr"}, addr[d], 64'h0);
      chk({p, " rst ival"}, 64'(ival[d]), 64'h0);
      chk({p, " rst inst"}, 64'(inst[d]), 64'h0);
      chk({p, " rst iaddr"}, iaddr[d], 64'h0);
      chk({p, " rst count"}, 64'(cnt_o[d]), 64'h0);
      mq[d].delete();
      mpc[d]   = rpc[d];
      mo[d]    = 0;
      mdrop[d] = 0;
      mc[d]    = 1;
      return;
    end
    ereq = !mo[d] && n < 4 && !redir[d];
    eiv  = n > 0 && (mc[d] || d == 0) && !redir[d];
    h    = eiv ? mq[d][0] : '0;
    chk({p, " req"}, 64'(req[d]), 64'(ereq));
    if (ereq) chk({p, " addr"}, addr[d], mpc[d]);
    chk({p, " ival"}, 64'(ival[d]), 64'(eiv));
    chk({p, " inst"}, 64'(inst[d]), 64'(h.inst));
    chk({p, " iaddr"}, iaddr[d], h.pc);
    chk({p, " count"}, 64'(cnt_o[d]), 64'(n));
    if (redir[d]) begin
      mq[d].delete();
      mpc[d]   = raddr[d];
      mc[d]    = 1;
      mdrop[d] = mo[d] && !vinst[d];
      mo[d]    = mo[d] && !vinst[d];
    end else begin
      if (eiv && rdy[d]) begin
        void'(mq[d].pop_front());
        mc[d] = 0;
      end else if (fin[d]) mc[d] = 1;
      if (vinst[d] && mo[d]) begin
        if (mdrop[d]) mdrop[d] = 0;
        else mq[d].push_back('{inst: idat[d], pc: mrpc[d]});
        mo[d] = 0;
      end
      if (ereq) begin
        mo[d]   = 1;
        mrpc[d] = mpc[d];
        mpc[d]  = mpc[d] + 64'd4;
        pend[d] = 1;
        lat[d]  = c < 70 ? 0 : int'($urandom_range(0, 2));
        pdat[d] = $urandom;
      end
    end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 0; redir[d] = 0; vinst[d] = 0; fin[d] = 0; rdy[d] = 0;
      raddr[d] = '0; idat[d] = '0; pend[d] = 0; stale[d] = 0; lat[d] = 0;
    end
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) drive(d, c);
      #1;
      for (int d = 0; d < 2; d++) step(d, c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
